cfg_tx_queue: RTL and testbench



---
 rtl/cfg_tx_pkg.sv | 29 ++
 rtl/cfg_tx_queue_if.sv | 33 +++
 rtl/cfg_tx_fifo.sv | 52 +++++
 rtl/cfg_tx_queue.sv | 190 +++++++++++++++++++
 tb/tb_cfg_tx_queue.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cfg_tx_pkg.sv
// Shared types and constants for the MCU configuration UART queue.
// Build option: CFG_TX_PARITY_EN selects 8E1 framing instead of 8N1.
package cfg_tx_pkg;

    localparam logic UART_IDLE  = 1'b1;
    localparam logic UART_START = 1'b0;

`ifdef CFG_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;
`endif

    function automatic logic even_par(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/cfg_tx_queue_if.sv
// Byte request, MCU ready and UART pin bundle of cfg_tx_queue.
// master = byte producer / board side, slave = the queue itself.
interface cfg_tx_queue_if;

    logic [7:0] tx_data;
    logic       new_tx_data;
    logic       cclk;
    logic       tx;
    logic       ready;
    logic       busy;
    logic       overflow;

    modport master (
        output tx_data,
        output new_tx_data,
        output cclk,
        input  tx,
        input  ready,
        input  busy,
        input  overflow
    );

    modport slave (
        input  tx_data,
        input  new_tx_data,
        input  cclk,
        output tx,
        output ready,
        output busy,
        output overflow
    );

endinterface

// File: rtl/cfg_tx_fifo.sv
// Byte FIFO with extra-MSB pointers and a sticky overflow flag.
// A pop frees its slot before a same-cycle push is judged.
module cfg_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       empty,
    output logic       overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wp;
    logic [AW:0] rp;
    logic [7:0]  mem [DEPTH];
    logic        full;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW]) &&
                     (wp[AW-1:0] == rp[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rp[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp       <= '0;
            rp       <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wp <= wp + (AW+1)'(1);
            if (do_pop)
                rp <= rp + (AW+1)'(1);
            if (push && !do_push)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wp[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/cfg_tx_queue.sv
// Queues config bytes and serialises them to the MCU once cclk is stable.
// Build option: CFG_TX_PARITY_EN inserts an even-parity bit (8E1).
module cfg_tx_queue
    import cfg_tx_pkg::*;
#(
    parameter int CLK_HZ      = 25_000_000,
    parameter int BAUD        = 500_000,
    parameter int DEPTH       = 4,
    parameter int CCLK_STABLE = 512
) (
    input  logic           clk,
    input  logic           rst_n,
    cfg_tx_queue_if.slave  bus
);

    localparam int CPB = CLK_HZ / BAUD;
    localparam int CW  = $clog2(CPB);
    localparam int SW  = $clog2(CCLK_STABLE + 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CPB - 1);
    localparam logic [SW-1:0] STAB_MAX  = SW'(CCLK_STABLE);

    if ((CLK_HZ % BAUD) != 0 || CPB < 4) begin : g_bad_baud
        $error("CLK_HZ/BAUD must be an integer >= 4");
    end
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0)
    begin : g_bad_depth
        $error("DEPTH must be a power of two in 2..16");
    end

    logic          new_q;
    logic          new_qq;
    logic          req;
    logic          cclk_s1;
    logic          cclk_s2;
    logic [SW-1:0] stab;
    logic          ready_w;
    logic [7:0]    rdata;
    logic          empty;
    logic          pop;
    logic          overflow_w;

    tx_state_t     state, state_n;
    logic [CW-1:0] baud, baud_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift, shift_n;
    logic          tx_q, tx_n;
    logic          last;
    logic          load;
`ifdef CFG_TX_PARITY_EN
    logic          par, par_n;
`endif

    // Producer holds the request level for several cycles; act on the edge.
    assign req = new_q & ~new_qq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            new_q   <= 1'b0;
            new_qq  <= 1'b0;
            cclk_s1 <= 1'b0;
            cclk_s2 <= 1'b0;
            stab    <= '0;
        end else begin
            new_q   <= bus.new_tx_data;
            new_qq  <= new_q;
            cclk_s1 <= bus.cclk;
            cclk_s2 <= cclk_s1;
            if (!cclk_s2)
                stab <= '0;
            else if (stab != STAB_MAX)
                stab <= stab + SW'(1);
        end
    end

    assign ready_w = (stab == STAB_MAX);

    cfg_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (req),
        .wdata    (bus.tx_data),
        .pop      (pop),
        .rdata    (rdata),
        .empty    (empty),
        .overflow (overflow_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            baud  <= '0;
            idx   <= '0;
            shift <= '0;
            tx_q  <= UART_IDLE;
`ifdef CFG_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            baud  <= baud_n;
            idx   <= idx_n;
            shift <= shift_n;
            tx_q  <= tx_n;
`ifdef CFG_TX_PARITY_EN
            par   <= par_n;
`endif
        end
    end

    assign last = (baud == BAUD_LAST);

    always_comb begin
        state_n = state;
        baud_n  = baud;
        idx_n   = idx;
        shift_n = shift;
        load    = 1'b0;
        pop     = 1'b0;
        tx_n    = UART_IDLE;
`ifdef CFG_TX_PARITY_EN
        par_n   = par;
`endif
        unique case (state)
            IDLE: begin
                load = ~empty & ready_w;
            end
            START: begin
                baud_n = last ? '0 : baud + CW'(1);
                if (last) begin
                    idx_n   = '0;
                    state_n = DATA;
                end
            end
            DATA: begin
                baud_n = last ? '0 : baud + CW'(1);
                if (last) begin
                    shift_n = {1'b0, shift[7:1]};
                    idx_n   = idx + 3'd1;
                    if (idx == 3'd7)
`ifdef CFG_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                end
            end
`ifdef CFG_TX_PARITY_EN
            PARITY: begin
                baud_n = last ? '0 : baud + CW'(1);
                if (last)
                    state_n = STOP;
            end
`endif
            STOP: begin
                baud_n = last ? '0 : baud + CW'(1);
                if (last) begin
                    state_n = IDLE;
                    load    = ~empty & ready_w;
                end
            end
            default: state_n = IDLE;
        endcase
        // Loading straight out of STOP keeps back-to-back frames gapless.
        if (load) begin
            pop     = 1'b1;
            state_n = START;
            baud_n  = '0;
            shift_n = rdata;
`ifdef CFG_TX_PARITY_EN
            par_n   = even_par(rdata);
`endif
        end
        unique case (state_n)
            START:   tx_n = UART_START;
            DATA:    tx_n = shift_n[0];
`ifdef CFG_TX_PARITY_EN
            PARITY:  tx_n = par_n;
`endif
            default: tx_n = UART_IDLE;
        endcase
    end

    assign bus.tx       = tx_q;
    assign bus.ready    = ready_w;
    assign bus.busy     = ~empty | (state != IDLE);
    assign bus.overflow = overflow_w;

endmodule

// File: tb/tb_cfg_tx_queue.sv
// Directed bench for cfg_tx_queue at default parameters.
// A line receiver decodes tx; each task checks its own scenario.
module tb_cfg_tx_queue;

    localparam int CPB = 50;
`ifdef CFG_TX_PARITY_EN
    localparam int FRAME = 11 * CPB;
`else
    localparam int FRAME = 10 * CPB;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    cfg_tx_queue_if bus ();

    cfg_tx_queue #(
        .CLK_HZ      (25_000_000),
        .BAUD        (500_000),
        .DEPTH       (4),
        .CCLK_STABLE (512)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #20 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] rx_byte [$];
    bit         rx_ok   [$];
    int         rx_start[$];
    logic       rx_par  [$];
    bit         mon_en   = 1'b1;
    bit         mon_busy = 1'b0;

    // Receiver samples each bit in its middle cycle.
    initial begin : monitor
        int         st;
        logic [7:0] b;
        bit         ok;
        logic       p;
        forever begin
            @(negedge clk);
            if (mon_en && bus.tx === 1'b0) begin
                mon_busy = 1'b1;
                st = cyc;
                ok = 1'b1;
                p  = 1'b0;
                repeat (CPB/2) @(negedge clk);
                if (bus.tx !== 1'b0) ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = bus.tx;
                end
`ifdef CFG_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                p = bus.tx;
                if (p !== ^b) ok = 1'b0;
`endif
                repeat (CPB) @(negedge clk);
                if (bus.tx !== 1'b1) ok = 1'b0;
                rx_byte.push_back(b);
                rx_ok.push_back(ok);
                rx_start.push_back(st);
                rx_par.push_back(p);
                repeat (CPB/2 - 1) @(negedge clk);
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #(40 * 90000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_rx();
        rx_byte.delete();
        rx_ok.delete();
        rx_start.delete();
        rx_par.delete();
    endtask

    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        bus.tx_data     = b;
        bus.new_tx_data = 1'b1;
        repeat (2) @(negedge clk);
        bus.new_tx_data = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name, input int limit);
        int k = 0;
        while ((bus.busy === 1'b1 || mon_busy) && k < limit) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || mon_busy) begin
            errors++;
            $display("FAIL %s: busy=%b after %0d cycles, required 0",
                     name, bus.busy, limit);
        end
    endtask

    task automatic wait_tx_low(output int k, input int limit);
        k = 0;
        while (bus.tx !== 1'b0 && k < limit) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic count_busy(output int n, input int limit);
        n = 0;
        while (bus.busy === 1'b1 && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic do_reset(output int rel);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rel = cyc;
    endtask

    task automatic test_reset();
        bus.tx_data     = 8'h00;
        bus.new_tx_data = 1'b0;
        bus.cclk        = 1'b0;
        #5;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 4;
        if (bus.tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx: got %b want 1", bus.tx);
        end
        if (bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0", bus.ready);
        end
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b want 0", bus.busy);
        end
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %b want 0", bus.overflow);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: tx=%b busy=%b want 1/0",
                     bus.tx, bus.busy);
        end
    endtask

    task automatic test_cold_start();
        int k;
        int rk;
        int n;
        clear_rx();
        push_byte(8'hA5);
        repeat (20) @(negedge clk);
        checks += 2;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL cold_busy: got %b want 1", bus.busy);
        end
        if (bus.tx !== 1'b1 || bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL cold_hold: tx=%b ready=%b want 1/0",
                     bus.tx, bus.ready);
        end
        @(posedge clk);
        #1;
        bus.cclk = 1'b1;
        k  = 0;
        rk = -1;
        while (bus.tx !== 1'b0 && k < 2000) begin
            @(posedge clk);
            #1;
            k++;
            if (bus.ready === 1'b1 && rk < 0) rk = k;
        end
        checks += 2;
        if (rk != 514) begin
            errors++;
            $display("FAIL cold_ready_lat: got %0d want 514", rk);
        end
        if (k != 515) begin
            errors++;
            $display("FAIL cold_start_lat: got %0d want 515", k);
        end
        count_busy(n, 2000);
        checks++;
        if (n != FRAME) begin
            errors++;
            $display("FAIL cold_frame_len: got %0d want %0d", n, FRAME);
        end
        wait_idle("cold_idle", 1000);
        checks++;
        if (rx_byte.size() != 1 || rx_byte[0] !== 8'hA5 || !rx_ok[0]) begin
            errors++;
            $display("FAIL cold_byte: frames=%0d byte=%h want 1/a5",
                     rx_byte.size(),
                     rx_byte.size() > 0 ? rx_byte[0] : 8'hxx);
        end
    endtask

    task automatic test_burst();
        clear_rx();
        for (int i = 1; i <= 5; i++)
            push_byte(8'(i));
        push_byte(8'h06);
        repeat (2) @(negedge clk);
        checks++;
        if (bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL burst_ovf: got %b want 1", bus.overflow);
        end
        wait_idle("burst_idle", 6000);
        checks++;
        if (rx_byte.size() != 5) begin
            errors++;
            $display("FAIL burst_count: got %0d want 5", rx_byte.size());
        end
        for (int i = 0; i < rx_byte.size() && i < 5; i++) begin
            checks++;
            if (rx_byte[i] !== 8'(i + 1) || !rx_ok[i]) begin
                errors++;
                $display("FAIL burst_byte%0d: got %h ok=%b want %h",
                         i, rx_byte[i], rx_ok[i], 8'(i + 1));
            end
        end
        for (int i = 1; i < rx_start.size() && i < 5; i++) begin
            checks++;
            if (rx_start[i] - rx_start[i-1] != FRAME) begin
                errors++;
                $display("FAIL burst_gap%0d: got %0d want %0d", i,
                         rx_start[i] - rx_start[i-1], FRAME);
            end
        end
    endtask

    task automatic test_simul_full();
        int         rel;
        logic [7:0] exp [5];
        exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        clear_rx();
        do_reset(rel);
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL simul_ovf_clr: got %b want 0", bus.overflow);
        end
        for (int i = 0; i < 4; i++)
            push_byte(exp[i]);
        while (cyc < rel + 513) @(negedge clk);
        bus.tx_data     = 8'h55;
        bus.new_tx_data = 1'b1;
        repeat (2) @(negedge clk);
        bus.new_tx_data = 1'b0;
        repeat (4) @(negedge clk);
        checks += 2;
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL simul_ovf: got %b want 0", bus.overflow);
        end
        if (bus.tx !== 1'b0) begin
            errors++;
            $display("FAIL simul_start: tx=%b want 0", bus.tx);
        end
        wait_idle("simul_idle", 4000);
        checks++;
        if (rx_byte.size() != 5) begin
            errors++;
            $display("FAIL simul_count: got %0d want 5", rx_byte.size());
        end
        for (int i = 0; i < rx_byte.size() && i < 5; i++) begin
            checks++;
            if (rx_byte[i] !== exp[i] || !rx_ok[i]) begin
                errors++;
                $display("FAIL simul_byte%0d: got %h want %h",
                         i, rx_byte[i], exp[i]);
            end
        end
    endtask

    task automatic test_level_hold();
        clear_rx();
        @(negedge clk);
        bus.tx_data     = 8'h3C;
        bus.new_tx_data = 1'b1;
        repeat (10) @(negedge clk);
        bus.tx_data = 8'hFF;
        repeat (90) @(negedge clk);
        bus.new_tx_data = 1'b0;
        bus.tx_data     = 8'h00;
        wait_idle("level_idle", 2000);
        repeat (100) @(negedge clk);
        checks++;
        if (rx_byte.size() != 1 || rx_byte[0] !== 8'h3C) begin
            errors++;
            $display("FAIL level_hold: frames=%0d first=%h want 1/3c",
                     rx_byte.size(),
                     rx_byte.size() > 0 ? rx_byte[0] : 8'hxx);
        end
    endtask

    task automatic test_cclk_drop();
        int k;
        clear_rx();
        push_byte(8'h96);
        push_byte(8'h69);
        wait_tx_low(k, 200);
        repeat (220) @(posedge clk);
        #1;
        bus.cclk = 1'b0;
        k = 0;
        while (rx_byte.size() < 1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        repeat (200) @(negedge clk);
        checks += 2;
        if (rx_byte.size() != 1 || rx_byte[0] !== 8'h96 || !rx_ok[0]) begin
            errors++;
            $display("FAIL drop_first: frames=%0d byte=%h want 1/96",
                     rx_byte.size(),
                     rx_byte.size() > 0 ? rx_byte[0] : 8'hxx);
        end
        if (bus.tx !== 1'b1 || bus.busy !== 1'b1 || bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL drop_hold: tx=%b busy=%b ready=%b want 1/1/0",
                     bus.tx, bus.busy, bus.ready);
        end
        @(posedge clk);
        #1;
        bus.cclk = 1'b1;
        wait_tx_low(k, 2000);
        checks++;
        if (k != 515) begin
            errors++;
            $display("FAIL drop_restart_lat: got %0d want 515", k);
        end
        wait_idle("drop_idle", 2000);
        checks++;
        if (rx_byte.size() != 2 || rx_byte[1] !== 8'h69) begin
            errors++;
            $display("FAIL drop_second: frames=%0d want 2 with 69",
                     rx_byte.size());
        end
    endtask

    task automatic test_reset_mid();
        int k;
        int lows;
        mon_en = 1'b0;
        push_byte(8'hC3);
        wait_tx_low(k, 200);
        repeat (120) @(posedge clk);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks += 2;
        if (bus.tx !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_tx: got %b want 1", bus.tx);
        end
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_busy: got %b want 0", bus.busy);
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (bus.tx !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_residual: low=%0d busy=%b want 0/0",
                     lows, bus.busy);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_frame_len();
        int k;
        int n;
        clear_rx();
        k = 0;
        while (bus.ready !== 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        push_byte(8'h07);
        wait_tx_low(k, 200);
        count_busy(n, 2000);
        checks++;
        if (n != FRAME) begin
            errors++;
            $display("FAIL len_07: got %0d want %0d", n, FRAME);
        end
        wait_idle("len_idle", 1000);
        checks++;
        if (rx_byte.size() != 1 || rx_byte[0] !== 8'h07 || !rx_ok[0]) begin
            errors++;
            $display("FAIL byte_07: frames=%0d want 1 clean 07",
                     rx_byte.size());
        end
`ifdef CFG_TX_PARITY_EN
        checks++;
        if (rx_par.size() != 1 || rx_par[0] !== 1'b1) begin
            errors++;
            $display("FAIL parity_07: frames=%0d want parity 1",
                     rx_par.size());
        end
`endif
    endtask

    initial begin
        test_reset();
        test_cold_start();
        test_burst();
        test_simul_full();
        test_level_hold();
        test_cclk_drop();
        test_reset_mid();
        test_frame_len();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
